// File: rtl/max_pool_pkg.sv
// max_pool_pkg
//   Shared definitions for the max-pool sequencer:
//   - state_e        : sequencer FSM states
//   - idx_width()    : width of a window-local index, clog2(stride^2)
//   - POOL_STRIDE    : pooling window edge the argmax entry type is sized for
//   - argmax_entry_t : one argmax memory entry (window-local index of the max)
package max_pool_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FWD       = 3'd1,
        ST_FWD_FLUSH = 3'd2,
        ST_BWD_LOAD  = 3'd3,
        ST_BWD_EMIT  = 3'd4
    } state_e;

    function automatic int idx_width(input int stride);
        return (stride * stride > 1) ? $clog2(stride * stride) : 1;
    endfunction

    // The argmax entry type is fixed by this stride; the top refuses to
    // elaborate with a STRIDE whose index width differs.
    localparam int POOL_STRIDE = 2;
    localparam int IDX_W       = idx_width(POOL_STRIDE);

    typedef logic [IDX_W-1:0] argmax_entry_t;

endpackage

// File: rtl/max_pool_argmax_mem.sv
// max_pool_argmax_mem
//   Argmax record for every pooling window. Cleared by reset, retained
//   across passes otherwise.
//   Ports:
//     clk, rst_n       : clock, asynchronous active-low reset (clears all)
//     wr_en/row/col    : forward-pass write of one window's argmax
//     wr_data          : window-local index of the maximum
//     rd_row/rd_col    : backward-pass read address
//     rd_data          : combinational read data
module max_pool_argmax_mem
    import max_pool_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int ROW_W = 4,
    parameter int COL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COL_W-1:0] wr_col,
    input  argmax_entry_t    wr_data,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output argmax_entry_t    rd_data
);

    argmax_entry_t mem_q [ROWS][COLS];
    argmax_entry_t mem_d [ROWS][COLS];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_row][wr_col] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_row][rd_col];

endmodule

// File: rtl/max_pool_sequencer.sv
// max_pool_sequencer
//   Streaming max-pool stage. Forward: consumes pixels in raster order,
//   emits one pooled value per STRIDE x STRIDE window and records the
//   argmax. Backward: per output row, loads a row of output gradients and
//   expands it into STRIDE full input rows of gradients, routing each
//   gradient to its window's recorded argmax position.
//   Ports:
//     clk, rst_n               : clock, asynchronous active-low reset
//     start, mode              : begin a pass (0 fwd, 1 bwd), sampled in IDLE
//     busy, done               : high outside IDLE / one-cycle end-of-pass pulse
//     in_*                     : input pixel stream (valid/ready)
//     out_*                    : pooled output stream (valid/ready)
//     grad_in_*                : output-gradient stream (valid/ready)
//     grad_out_*               : input-gradient stream (valid/ready)
//   Handshake: a beat transfers on a rising edge where valid && ready; a
//   source holds valid and data stable until that edge.
module max_pool_sequencer
    import max_pool_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int STRIDE           = POOL_STRIDE,
    parameter int INPUT_DIM_WIDTH  = 32,
    parameter int INPUT_DIM_HEIGHT = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [WIDTH-1:0] out_data,
    input  logic                    grad_in_valid,
    output logic                    grad_in_ready,
    input  logic signed [WIDTH-1:0] grad_in_data,
    output logic                    grad_out_valid,
    input  logic                    grad_out_ready,
    output logic        [WIDTH-1:0] grad_out_data
);

    localparam int OUTPUT_DIM_WIDTH  = INPUT_DIM_WIDTH / STRIDE;
    localparam int OUTPUT_DIM_HEIGHT = INPUT_DIM_HEIGHT / STRIDE;
    localparam int OW      = OUTPUT_DIM_WIDTH;
    localparam int OH      = OUTPUT_DIM_HEIGHT;
    localparam int R_W     = $clog2(INPUT_DIM_HEIGHT);
    localparam int C_W     = $clog2(INPUT_DIM_WIDTH);
    localparam int OR_W    = (OH > 1) ? $clog2(OH) : 1;
    localparam int OC_W    = (OW > 1) ? $clog2(OW) : 1;
    localparam int LAST_LI = STRIDE * STRIDE - 1;

    if (STRIDE < 2) begin : g_bad_stride
        $error("max_pool_sequencer: STRIDE must be at least 2");
    end
    if ((INPUT_DIM_WIDTH % STRIDE) != 0 || (INPUT_DIM_HEIGHT % STRIDE) != 0) begin : g_bad_dim
        $error("max_pool_sequencer: input dimensions must be divisible by STRIDE");
    end
    if (idx_width(STRIDE) != IDX_W) begin : g_bad_idx
        $error("max_pool_sequencer: STRIDE does not match POOL_STRIDE in max_pool_pkg");
    end

    function automatic argmax_entry_t li_of(input logic [R_W-1:0] r, input logic [C_W-1:0] c);
        return IDX_W'((int'(r) % STRIDE) * STRIDE + (int'(c) % STRIDE));
    endfunction

    function automatic logic [OC_W-1:0] oc_of(input logic [C_W-1:0] c);
        return OC_W'(int'(c) / STRIDE);
    endfunction

    function automatic logic [OR_W-1:0] or_of(input logic [R_W-1:0] r);
        return OR_W'(int'(r) / STRIDE);
    endfunction

    state_e                  state_q, state_d;
    logic [R_W-1:0]          r_q, r_d;
    logic [C_W-1:0]          c_q, c_d;
    logic [OC_W-1:0]         g_q, g_d;   // gradient load column
    logic signed [WIDTH-1:0] pbuf_val_q [OW];
    logic signed [WIDTH-1:0] pbuf_val_d [OW];
    argmax_entry_t           pbuf_idx_q [OW];
    argmax_entry_t           pbuf_idx_d [OW];
    logic signed [WIDTH-1:0] grow_q [OW];
    logic signed [WIDTH-1:0] grow_d [OW];
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_data_q, out_data_d;
    logic                    grad_out_valid_q, grad_out_valid_d;
    logic signed [WIDTH-1:0] grad_out_data_q, grad_out_data_d;
    logic                    done_q, done_d;

    logic busy_w, in_ready_w, grad_in_ready_w;
    logic in_fire, out_fire, gin_fire, gout_fire;
    logic last_pix, row_end, group_end, last_group;
    argmax_entry_t           cur_li, cand_idx;
    logic [OC_W-1:0]         cur_oc, pos_oc;
    logic signed [WIDTH-1:0] cand_val, emit_grow, emit_val;
    logic [R_W-1:0]          pos_r;
    logic [C_W-1:0]          pos_c;
    logic                    am_we;
    argmax_entry_t           am_rd_data;

    assign in_fire   = in_valid && in_ready_w;
    assign out_fire  = out_valid_q && out_ready;
    assign gin_fire  = grad_in_valid && grad_in_ready_w;
    assign gout_fire = grad_out_valid_q && grad_out_ready;

    // Position flags, window candidate and next backward emit value.
    always_comb begin
        cur_li     = li_of(r_q, c_q);
        cur_oc     = oc_of(c_q);
        row_end    = (c_q == C_W'(INPUT_DIM_WIDTH - 1));
        last_group = (r_q == R_W'(INPUT_DIM_HEIGHT - 1));
        last_pix   = row_end && last_group;
        group_end  = ((int'(r_q) % STRIDE) == STRIDE - 1);
        // Strict signed compare: ties keep the earlier raster position.
        if (cur_li == '0 || in_data > pbuf_val_q[cur_oc]) begin
            cand_val = in_data;
            cand_idx = cur_li;
        end else begin
            cand_val = pbuf_val_q[cur_oc];
            cand_idx = pbuf_idx_q[cur_oc];
        end
        // pos is the position whose gradient loads the output register at
        // the next edge: the current position when entering emit, else the
        // successor of the one just handed off.
        pos_r = r_q;
        pos_c = c_q;
        if (state_q == ST_BWD_EMIT) begin
            if (row_end) begin
                pos_r = r_q + 1'b1;
                pos_c = '0;
            end else begin
                pos_c = c_q + 1'b1;
            end
        end
        pos_oc    = oc_of(pos_c);
        // A gradient accepted this cycle is not yet in grow_q.
        emit_grow = (gin_fire && g_q == pos_oc) ? grad_in_data : grow_q[pos_oc];
        emit_val  = (am_rd_data == li_of(pos_r, pos_c)) ? emit_grow : '0;
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = mode ? ST_BWD_LOAD : ST_FWD;
            ST_FWD:       if (in_fire && last_pix) state_d = ST_FWD_FLUSH;
            ST_FWD_FLUSH: if (out_fire) state_d = ST_IDLE;
            ST_BWD_LOAD:  if (gin_fire && g_q == OC_W'(OW - 1)) state_d = ST_BWD_EMIT;
            ST_BWD_EMIT:  if (gout_fire && row_end && group_end)
                              state_d = last_group ? ST_IDLE : ST_BWD_LOAD;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        busy_w          = (state_q != ST_IDLE);
        in_ready_w      = (state_q == ST_FWD) && !(out_valid_q && !out_ready);
        grad_in_ready_w = (state_q == ST_BWD_LOAD);
    end

    // Datapath next values.
    always_comb begin
        r_d              = r_q;
        c_d              = c_q;
        g_d              = g_q;
        pbuf_val_d       = pbuf_val_q;
        pbuf_idx_d       = pbuf_idx_q;
        grow_d           = grow_q;
        out_valid_d      = out_valid_q;
        out_data_d       = out_data_q;
        grad_out_valid_d = grad_out_valid_q;
        grad_out_data_d  = grad_out_data_q;
        done_d           = 1'b0;
        am_we            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                r_d = '0;
                c_d = '0;
                g_d = '0;
            end
            ST_FWD: begin
                if (out_fire) out_valid_d = 1'b0;
                if (in_fire) begin
                    pbuf_val_d[cur_oc] = cand_val;
                    pbuf_idx_d[cur_oc] = cand_idx;
                    if (cur_li == IDX_W'(LAST_LI)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = cand_val;
                        am_we       = 1'b1;
                    end
                    if (row_end) begin
                        c_d = '0;
                        r_d = last_group ? '0 : r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            ST_FWD_FLUSH: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            ST_BWD_LOAD: begin
                if (gin_fire) begin
                    grow_d[g_q] = grad_in_data;
                    if (g_q == OC_W'(OW - 1)) begin
                        g_d              = '0;
                        grad_out_valid_d = 1'b1;
                        grad_out_data_d  = emit_val;
                    end else begin
                        g_d = g_q + 1'b1;
                    end
                end
            end
            ST_BWD_EMIT: begin
                if (gout_fire) begin
                    if (row_end && group_end) begin
                        grad_out_valid_d = 1'b0;
                        c_d              = '0;
                        r_d              = last_group ? '0 : r_q + 1'b1;
                        done_d           = last_group;
                    end else begin
                        r_d             = pos_r;
                        c_d             = pos_c;
                        grad_out_data_d = emit_val;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q              <= '0;
            c_q              <= '0;
            g_q              <= '0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            grad_out_valid_q <= 1'b0;
            grad_out_data_q  <= '0;
            done_q           <= 1'b0;
            for (int i = 0; i < OW; i++) begin
                pbuf_val_q[i] <= '0;
                pbuf_idx_q[i] <= '0;
                grow_q[i]     <= '0;
            end
        end else begin
            r_q              <= r_d;
            c_q              <= c_d;
            g_q              <= g_d;
            pbuf_val_q       <= pbuf_val_d;
            pbuf_idx_q       <= pbuf_idx_d;
            grow_q           <= grow_d;
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            grad_out_valid_q <= grad_out_valid_d;
            grad_out_data_q  <= grad_out_data_d;
            done_q           <= done_d;
        end
    end

    max_pool_argmax_mem #(
        .ROWS  (OH),
        .COLS  (OW),
        .ROW_W (OR_W),
        .COL_W (OC_W)
    ) u_argmax_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (am_we),
        .wr_row  (or_of(r_q)),
        .wr_col  (cur_oc),
        .wr_data (cand_idx),
        .rd_row  (or_of(pos_r)),
        .rd_col  (pos_oc),
        .rd_data (am_rd_data)
    );

    assign busy           = busy_w;
    assign done           = done_q;
    assign in_ready       = in_ready_w;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign grad_in_ready  = grad_in_ready_w;
    assign grad_out_valid = grad_out_valid_q;
    assign grad_out_data  = grad_out_data_q;

endmodule

// File: tb/tb_max_pool_sequencer.sv
// tb_max_pool_sequencer
//   Bench for max_pool_sequencer on a 4x4 map with STRIDE=2. A reference
//   model computes pooled outputs, argmax and expanded gradients directly
//   from window arithmetic; DUT streams are compared beat by beat.
module tb_max_pool_sequencer;

    localparam int W    = 16;
    localparam int S    = 2;
    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int OW   = IW / S;
    localparam int OH   = IH / S;
    localparam int NPIX = IW * IH;
    localparam int NOUT = OW * OH;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start, mode, busy, done;
    logic in_valid, in_ready, out_valid, out_ready;
    logic signed [W-1:0] in_data;
    logic [W-1:0] out_data;
    logic grad_in_valid, grad_in_ready, grad_out_valid, grad_out_ready;
    logic signed [W-1:0] grad_in_data;
    logic [W-1:0] grad_out_data;

    always #5 clk = ~clk;

    max_pool_sequencer #(
        .WIDTH            (W),
        .STRIDE           (S),
        .INPUT_DIM_WIDTH  (IW),
        .INPUT_DIM_HEIGHT (IH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mode           (mode),
        .busy           (busy),
        .done           (done),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .grad_in_valid  (grad_in_valid),
        .grad_in_ready  (grad_in_ready),
        .grad_in_data   (grad_in_data),
        .grad_out_valid (grad_out_valid),
        .grad_out_ready (grad_out_ready),
        .grad_out_data  (grad_out_data)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic signed [31:0] exp_q[$];
    int pix   [NPIX];
    int grads [NOUT];
    int am    [NOUT];   // model argmax, window-local index per window

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pix_at(input int r, input int c);
        return pix[r * IW + c];
    endfunction

    function automatic void model_fwd();
        int best, bi, v;
        exp_q.delete();
        for (int wy = 0; wy < OH; wy++) begin
            for (int wx = 0; wx < OW; wx++) begin
                best = pix_at(wy * S, wx * S);
                bi   = 0;
                for (int k = 1; k < S * S; k++) begin
                    v = pix_at(wy * S + k / S, wx * S + k % S);
                    if (v > best) begin
                        best = v;
                        bi   = k;
                    end
                end
                exp_q.push_back(best);
                am[wy * OW + wx] = bi;
            end
        end
    endfunction

    function automatic void model_bwd();
        int w, k;
        exp_q.delete();
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                w = (r / S) * OW + c / S;
                k = (r % S) * S + c % S;
                exp_q.push_back((am[w] == k) ? grads[w] : 0);
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        start = 1'b0; mode = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        grad_in_valid = 1'b0; grad_in_data = '0; grad_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_eq("rst_busy",           32'(busy), 0);
        check_eq("rst_done",           32'(done), 0);
        check_eq("rst_in_ready",       32'(in_ready), 0);
        check_eq("rst_out_valid",      32'(out_valid), 0);
        check_eq("rst_out_data",       32'(out_data), 0);
        check_eq("rst_grad_in_ready",  32'(grad_in_ready), 0);
        check_eq("rst_grad_out_valid", 32'(grad_out_valid), 0);
        check_eq("rst_grad_out_data",  32'(grad_out_data), 0);
        for (int i = 0; i < NOUT; i++) am[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic m);
        @(negedge clk);
        start = 1'b1; mode = m;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        #1;
        check_eq("busy_after_start", 32'(busy), 1);
    endtask

    task automatic run_fwd(input int stall_len, input bit poke);
        int sent = 0, got = 0, cyc = 0, stall = 0;
        bit lat_pend = 0, hold_pend = 0, done_pend = 0, first_seen = 0, fin = 0;
        logic signed [31:0] hold_val = 0;
        model_fwd();
        pulse_start(1'b0);
        while (!fin && cyc < 500) begin
            in_valid = (sent < NPIX) && ($urandom_range(0, 3) != 0);
            in_data  = W'(pix[(sent < NPIX) ? sent : 0]);
            if (stall_len > 0 && !first_seen && out_valid) begin
                first_seen = 1;
                stall      = stall_len;
            end
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = ($urandom_range(0, 4) != 0);
            end
            start = poke && (sent == 6);
            mode  = start;
            #1;
            if (lat_pend) begin
                check_eq("fwd_latency_valid", 32'(out_valid), 1);
                if (exp_q.size() > 0) check_eq("fwd_latency_data", 32'($signed(out_data)), exp_q[0]);
                lat_pend = 0;
            end
            if (hold_pend) begin
                check_eq("fwd_hold_valid", 32'(out_valid), 1);
                check_eq("fwd_hold_data", 32'($signed(out_data)), hold_val);
                hold_pend = 0;
            end
            if (done_pend) begin
                check_eq("fwd_done_timing", 32'(done), 1);
                check_eq("fwd_busy_at_done", 32'(busy), 0);
                done_pend = 0;
            end
            check_eq("fwd_bwd_ports_idle", 32'({grad_in_ready, grad_out_valid}), 0);
            if (done) fin = 1;
            if (out_valid && !out_ready) begin
                check_eq("fwd_in_ready_blocked", 32'(in_ready), 0);
                hold_pend = 1;
                hold_val  = $signed(out_data);
            end
            if (in_valid && in_ready) begin
                if (((sent / IW) % S == S - 1) && ((sent % IW) % S == S - 1)) lat_pend = 1;
                sent++;
            end
            if (out_valid && out_ready) begin
                got++;
                if (exp_q.size() > 0) check_eq("fwd_out", 32'($signed(out_data)), exp_q.pop_front());
                if (got == NOUT) done_pend = 1;
            end
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        check_eq("fwd_finished", 32'(fin), 1);
        check_eq("fwd_out_count", got, NOUT);
        check_eq("fwd_pix_count", sent, NPIX);
        #1;
        check_eq("fwd_done_pulse", 32'(done), 0);
        check_eq("fwd_busy_after", 32'(busy), 0);
    endtask

    task automatic run_bwd();
        int gi = 0, got = 0, cyc = 0;
        bit lat_pend = 0, hold_pend = 0, done_pend = 0, fin = 0;
        logic signed [31:0] hold_val = 0;
        model_bwd();
        pulse_start(1'b1);
        while (!fin && cyc < 500) begin
            grad_in_valid  = (gi < NOUT) && ($urandom_range(0, 3) != 0);
            grad_in_data   = W'(grads[(gi < NOUT) ? gi : 0]);
            grad_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (lat_pend) begin
                check_eq("bwd_latency_valid", 32'(grad_out_valid), 1);
                if (exp_q.size() > 0) check_eq("bwd_latency_data", 32'($signed(grad_out_data)), exp_q[0]);
                lat_pend = 0;
            end
            if (hold_pend) begin
                check_eq("bwd_hold_valid", 32'(grad_out_valid), 1);
                check_eq("bwd_hold_data", 32'($signed(grad_out_data)), hold_val);
                hold_pend = 0;
            end
            if (done_pend) begin
                check_eq("bwd_done_timing", 32'(done), 1);
                check_eq("bwd_busy_at_done", 32'(busy), 0);
                done_pend = 0;
            end
            check_eq("bwd_fwd_ports_idle", 32'({in_ready, out_valid}), 0);
            if (done) fin = 1;
            if (grad_out_valid && !grad_out_ready) begin
                hold_pend = 1;
                hold_val  = $signed(grad_out_data);
            end
            if (grad_in_valid && grad_in_ready) begin
                gi++;
                if (gi % OW == 0) lat_pend = 1;
            end
            if (grad_out_valid && grad_out_ready) begin
                got++;
                if (exp_q.size() > 0) check_eq("bwd_out", 32'($signed(grad_out_data)), exp_q.pop_front());
                if (got == NPIX) done_pend = 1;
            end
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        check_eq("bwd_finished", 32'(fin), 1);
        check_eq("bwd_out_count", got, NPIX);
        check_eq("bwd_grad_count", gi, NOUT);
        #1;
        check_eq("bwd_done_pulse", 32'(done), 0);
        check_eq("bwd_busy_after", 32'(busy), 0);
    endtask

    task automatic run_fwd_partial(input int n);
        int sent = 0, cyc = 0;
        pulse_start(1'b0);
        while (sent < n && cyc < 100) begin
            in_valid  = 1'b1;
            in_data   = W'(pix[sent]);
            out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        check_eq("partial_sent", sent, n);
    endtask

    task automatic set_grads(input int g0, input int g1, input int g2, input int g3);
        grads[0] = g0; grads[1] = g1; grads[2] = g2; grads[3] = g3;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic signed [W-1:0] t;
        idle_inputs();
        do_reset();

        // 1: ramp 0..15
        for (int i = 0; i < NPIX; i++) pix[i] = i;
        run_fwd(0, 0);
        // 3: backward after ramp
        set_grads(10, 20, 30, 40);
        run_bwd();

        // 2: all -3, then a window exercising the signed compare
        for (int i = 0; i < NPIX; i++) pix[i] = -3;
        run_fwd(0, 0);
        set_grads(5, -6, 7, -8);
        run_bwd();
        pix[0] = -8; pix[1] = -2; pix[4] = -5; pix[5] = -1;
        run_fwd(0, 0);
        set_grads(11, 12, 13, 14);
        run_bwd();

        // 4: output stall after the first pooled value
        for (int i = 0; i < NPIX; i++) pix[i] = i;
        run_fwd(5, 0);

        // 5: reset mid-forward, then backward on cleared argmax
        run_fwd_partial(6);
        do_reset();
        set_grads(1, 2, 3, 4);
        run_bwd();

        // 6: start with mode=1 during forward is ignored
        for (int i = 0; i < NPIX; i++) pix[i] = NPIX - i;
        run_fwd(0, 1);
        set_grads(-1, -2, -3, -4);
        run_bwd();

        // random passes, small value range to provoke ties
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < NPIX; i++) begin
                if (p % 2 == 0) begin
                    t = W'($urandom);
                    pix[i] = t;
                end else begin
                    pix[i] = int'($urandom_range(0, 3)) - 2;
                end
            end
            run_fwd((p == 3) ? 3 : 0, 0);
            for (int i = 0; i < NOUT; i++) begin
                t = W'($urandom);
                grads[i] = t;
            end
            run_bwd();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
